// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and defaults for the SSRAM port arbiter
package sram_arb_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DATA_W_DEFAULT = 32;
    localparam int NUM_CORES      = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant decision, purely combinational
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SSRAM port between two L1 caches, one whole transaction per grant
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int RD_LAT = 2
) (
    input  logic                 new_clock,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wd0,
    input  logic [DATA_W-1:0]    wd1,
    output logic [DATA_W-1:0]    rdata,
    output logic [NUM_CORES-1:0] done,
    output logic [NUM_CORES-1:0] StallMe,
    output logic [ADDR_W-1:0]    memory_address_out,
    output logic [DATA_W-1:0]    SRAM_WD,
    input  logic [DATA_W-1:0]    SRAM_RD,
    output logic                 SRAMGW,
    output logic                 SRAMOE,
    output logic [NUM_CORES-1:0] Invalidate,
    output logic [ADDR_W-1:0]    inval_addr
);

    // RD_LAT is 1..7, so the last wait count always fits in three bits
    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

    arb_state_t          state;
    arb_state_t          next_state;
    logic                gnt_valid;
    logic                gnt_idx;
    logic                gnt;
    logic                last_grant;
    logic                we_q;
    logic [2:0]          wait_cnt;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wd;

    rr_arbiter_2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign sel_we   = we[gnt_idx];
    assign sel_addr = gnt_idx ? addr1 : addr0;
    assign sel_wd   = gnt_idx ? wd1 : wd0;

    always_ff @(posedge new_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        done       = '0;
        Invalidate = '0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    next_state = sel_we ? WRITE : READ;
                end
            end
            READ: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = DONE;
                end
            end
            WRITE: next_state = DONE;
            DONE: begin
                next_state = IDLE;
                done[gnt] = 1'b1;
                if (we_q) begin
                    Invalidate[~gnt] = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // memory_address_out doubles as the latched transaction address
    assign inval_addr = memory_address_out;
    assign StallMe    = req & ~done;

    always_ff @(posedge new_clock) begin
        if (reset) begin
            last_grant         <= 1'b1;
            gnt                <= 1'b0;
            we_q               <= 1'b0;
            wait_cnt           <= 3'd0;
            memory_address_out <= '0;
            SRAM_WD            <= '0;
            rdata              <= '0;
            SRAMGW             <= 1'b1;
            SRAMOE             <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt                <= gnt_idx;
                        last_grant         <= gnt_idx;
                        we_q               <= sel_we;
                        memory_address_out <= sel_addr;
                        SRAM_WD            <= sel_wd;
                        wait_cnt           <= 3'd0;
                        SRAMOE             <= sel_we;
                        SRAMGW             <= ~sel_we;
                    end
                end
                READ: begin
                    if (wait_cnt == WAIT_LAST) begin
                        rdata    <= SRAM_RD;
                        SRAMOE   <= 1'b1;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                WRITE: SRAMGW <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter against a transaction-level model
module tb_sram_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              new_clock = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        done;
    logic [1:0]        StallMe;
    logic [ADDR_W-1:0] memory_address_out;
    logic [DATA_W-1:0] SRAM_WD;
    logic [DATA_W-1:0] SRAM_RD;
    logic              SRAMGW;
    logic              SRAMOE;
    logic [1:0]        Invalidate;
    logic [ADDR_W-1:0] inval_addr;

    int checks = 0;
    int errors = 0;
    int m_last;
    logic [DATA_W-1:0] ref_mem  [64];
    logic [DATA_W-1:0] sram_mem [64];
    int oe_run = 0;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .new_clock          (new_clock),
        .reset              (reset),
        .req                (req),
        .we                 (we),
        .addr0              (addr0),
        .addr1              (addr1),
        .wd0                (wd0),
        .wd1                (wd1),
        .rdata              (rdata),
        .done               (done),
        .StallMe            (StallMe),
        .memory_address_out (memory_address_out),
        .SRAM_WD            (SRAM_WD),
        .SRAM_RD            (SRAM_RD),
        .SRAMGW             (SRAMGW),
        .SRAMOE             (SRAMOE),
        .Invalidate         (Invalidate),
        .inval_addr         (inval_addr)
    );

    always #5 new_clock = ~new_clock;

    // SSRAM model: data appears only once OE has been low for RD_LAT cycles
    always @(posedge new_clock) begin
        if (!SRAMGW) sram_mem[memory_address_out] <= SRAM_WD;
        if (!SRAMOE) oe_run <= oe_run + 1;
        else         oe_run <= 0;
    end
    assign SRAM_RD = (!SRAMOE && oe_run >= RD_LAT - 1) ? sram_mem[memory_address_out] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve n transactions from the current req pattern; drop a core's req on its done if asked
    task automatic serve(input int n, input bit drop);
        int c, cyc, oe_cnt, gw_cnt, lat;
        bit got, wr;
        logic [ADDR_W-1:0] a, gw_addr;
        logic [DATA_W-1:0] d, gw_data;
        for (int k = 0; k < n; k++) begin
            if (req == 2'b11) c = (m_last == 1) ? 0 : 1;
            else              c = req[1] ? 1 : 0;
            wr  = we[c];
            a   = (c == 1) ? addr1 : addr0;
            d   = (c == 1) ? wd1 : wd0;
            lat = wr ? 3 : RD_LAT + 2;
            cyc = (k == 0) ? 1 : 0;
            oe_cnt = 0; gw_cnt = 0; got = 0;
            gw_addr = '0; gw_data = '0;
            while (cyc < 40 && !got) begin
                @(negedge new_clock);
                cyc++;
                if (!SRAMOE) oe_cnt++;
                if (!SRAMGW) begin
                    gw_cnt++;
                    gw_addr = memory_address_out;
                    gw_data = SRAM_WD;
                end
                chk("strobe_excl", 32'(SRAMGW | SRAMOE), 32'd1);
                if (done != 2'b00) got = 1;
                else chk("stall_wait", 32'(StallMe), 32'(req));
            end
            chk("timeout", 32'(got), 32'd1);
            chk("done_core", 32'(done), (c == 1) ? 32'd2 : 32'd1);
            chk("latency", 32'(cyc), 32'(lat));
            chk("stall_done", 32'(StallMe), 32'(req & ((c == 1) ? 2'b01 : 2'b10)));
            if (wr) begin
                chk("gw_cycles", 32'(gw_cnt), 32'd1);
                chk("gw_addr", 32'(gw_addr), 32'(a));
                chk("gw_data", gw_data, d);
                chk("oe_on_write", 32'(oe_cnt), 32'd0);
                chk("inval", 32'(Invalidate), (c == 1) ? 32'd1 : 32'd2);
                chk("inval_addr", 32'(inval_addr), 32'(a));
                ref_mem[a] = d;
            end else begin
                chk("oe_cycles", 32'(oe_cnt), 32'(RD_LAT));
                chk("gw_on_read", 32'(gw_cnt), 32'd0);
                chk("rdata", rdata, ref_mem[a]);
                chk("inval_read", 32'(Invalidate), 32'd0);
            end
            m_last = c;
            if (drop) req[c] = 1'b0;
        end
    endtask

    task automatic idle_chk();
        @(negedge new_clock);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_stall", 32'(StallMe), 32'(req));
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic [ADDR_W-1:0] wa;
        reset = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            sram_mem[i] = v;
        end
        ref_mem[5] = 32'hDEAD_BEEF;
        sram_mem[5] = 32'hDEAD_BEEF;
        m_last = 1;

        repeat (2) @(negedge new_clock);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_inval", 32'(Invalidate), 32'd0);
        chk("rst_gw", 32'(SRAMGW), 32'd1);
        chk("rst_oe", 32'(SRAMOE), 32'd1);
        chk("rst_addr", 32'(memory_address_out), 32'd0);
        chk("rst_wd", SRAM_WD, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge new_clock);

        // both from reset: core 0 reads 0x05, core 1 writes 0x12345678 to 0x3F
        req = 2'b11; we = 2'b10; addr0 = 6'h05; addr1 = 6'h3F; wd1 = 32'h1234_5678;
        serve(2, 1);
        idle_chk();

        req = 2'b01; we = 2'b00; addr0 = 6'h05;
        serve(1, 1);
        idle_chk();
        req = 2'b01; we = 2'b00; addr0 = 6'h3F;
        serve(1, 1);
        idle_chk();

        // continuous contention alternates cores
        req = 2'b11; we = 2'($urandom);
        addr0 = 6'($urandom); addr1 = 6'($urandom); wd0 = $urandom; wd1 = $urandom;
        serve(6, 0);
        req = 2'b00;
        idle_chk();

        // reset during second READ cycle abandons the transaction
        req = 2'b01; we = 2'b00; addr0 = 6'($urandom);
        repeat (2) @(negedge new_clock);
        reset = 1'b1;
        @(negedge new_clock);
        chk("rstmid_oe", 32'(SRAMOE), 32'd1);
        chk("rstmid_gw", 32'(SRAMGW), 32'd1);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_inval", 32'(Invalidate), 32'd0);
        reset = 1'b0; req = 2'b00; m_last = 1;
        idle_chk();
        req = 2'b01; we = 2'b00;
        serve(1, 1);
        idle_chk();

        // core 0 drops req mid-write
        wa = 6'($urandom);
        req = 2'b01; we = 2'b01; addr0 = wa; wd0 = $urandom;
        @(negedge new_clock);
        chk("drop_gw", 32'(SRAMGW), 32'd0);
        req = 2'b00;
        @(negedge new_clock);
        chk("drop_done", 32'(done), 32'd1);
        chk("drop_inval", 32'(Invalidate), 32'd2);
        chk("drop_inval_addr", 32'(inval_addr), 32'(wa));
        chk("drop_stall", 32'(StallMe), 32'd0);
        ref_mem[wa] = wd0;
        m_last = 0;
        repeat (2) begin
            @(negedge new_clock);
            chk("drop_nogrant", 32'({done, SRAMGW, SRAMOE}), 32'b0011);
        end
        req = 2'b01; we = 2'b00;
        serve(1, 1);
        idle_chk();

        for (int r = 0; r < 12; r++) begin
            req = 2'($urandom_range(1, 3)); we = 2'($urandom);
            addr0 = 6'($urandom); addr1 = 6'($urandom); wd0 = $urandom; wd1 = $urandom;
            serve((req == 2'b11) ? 2 : 1, 1);
            idle_chk();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the single off-chip SSRAM port between the L1 caches of core 0 and core 1.
- Grants one whole transaction at a time with round-robin fairness, sequences the SSRAM control strobes, and stalls each core's pipeline (StallMe) while its request is outstanding.
- On every completed write it broadcasts an invalidate of that address to the other core's cache.

## Interface
Parameters:
- ADDR_W, 6, SSRAM word address width
- DATA_W, 32, data width
- RD_LAT, 2, SSRAM read latency in cycles from address/OE valid to data valid; legal range 1..7

Ports:
- new_clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-core request, bit i = core i; held high until done[i]
- we  in  2  per-core write flag (1 = write, 0 = read); stable while req high
- addr0, addr1  in  ADDR_W each  per-core address; stable while req high
- wd0, wd1  in  DATA_W each  per-core write data; stable while req high
- rdata  out  DATA_W  read data; valid only in a cycle where done[i] is high and we[i] = 0
- done  out  2  one-cycle completion pulse to the granted core
- StallMe  out  2  combinational, StallMe[i] = req[i] & ~done[i]
- memory_address_out  out  ADDR_W  SSRAM address (registered)
- SRAM_WD  out  DATA_W  SSRAM write data (registered)
- SRAM_RD  in  DATA_W  SSRAM read data
- SRAMGW  out  1  active-low global write strobe
- SRAMOE  out  1  active-low output enable
- Invalidate  out  2  one-cycle pulse, bit j = invalidate core j's line
- inval_addr  out  ADDR_W  address for Invalidate; valid while Invalidate is nonzero

## Operation
- State machine in package enum: IDLE, READ, WRITE, DONE.
- Arbitration happens only in IDLE:
  - If exactly one req bit is high, grant that core.
  - If both are high, grant ~last_grant.
  - last_grant updates on each grant.
- Granted core index (gnt), address, we, and wd are latched on the grant edge.
- IDLE -> READ:
  - Driven on grant when we[gnt] = 0.
  - SRAMOE = 0 and memory_address_out = latched address for every READ cycle.
  - wait_cnt counts from 0; at wait_cnt = RD_LAT - 1, SRAM_RD is captured into rdata and the state moves to DONE.
- IDLE -> WRITE:
  - Driven on grant when we[gnt] = 1.
  - SRAMGW = 0 for exactly one cycle with address and SRAM_WD valid, then DONE.
- DONE:
  - done[gnt] = 1 for one cycle, then IDLE.
  - For a write, Invalidate[~gnt] = 1 and inval_addr = latched address in the same cycle.
- A req dropped mid-transaction does not abort it: the transaction completes and done still pulses.
- A requester that keeps req high after done is treated as a new request in IDLE.
- Reset values:
  - state = IDLE, last_grant = 1 (core 0 wins the first tie).
  - done = 0, Invalidate = 0, SRAMGW = 1, SRAMOE = 1.
  - memory_address_out = 0, SRAM_WD = 0, rdata = 0, wait_cnt = 0.
- Reset mid-transaction: the transaction is abandoned. No done and no Invalidate are issued, and the strobes return high on the next edge.

## Timing
- Request sampled in IDLE at edge 0 → strobes valid from edge 1.
- Read: done high in cycle RD_LAT + 1 after the grant edge; req-to-done = RD_LAT + 2 cycles (4 at default).
- Write: done high 2 cycles after the grant edge; req-to-done = 3 cycles.
- Back-to-back transactions: one IDLE cycle between DONE and the next grant. Each core waits at most one full transaction of the other.
- StallMe has no register stage: it falls in the same cycle done rises. This lets the pipeline registers advance on that edge.
- SRAMGW and SRAMOE are never low simultaneously.

## Structure
- Shared package sram_arb_pkg holds:
  - state enum typedef (IDLE/READ/WRITE/DONE);
  - ADDR_W/DATA_W defaults;
  - NUM_CORES = 2.
- One sub-module, rr_arbiter_2:
  - inputs: req[1:0], last_grant;
  - outputs: gnt_valid, gnt_idx;
  - purely combinational.
- The FSM, latches and wait counter live in sram_arbiter.

## Test plan
- Core 0 reads addr 0x05, SRAM model returns 0xDEADBEEF after 2 cycles → SRAMOE low 2 cycles, done = 01 at cycle 4, rdata = 0xDEADBEEF, StallMe[0] high cycles 0–3.
- Core 1 writes 0x12345678 to addr 0x3F → SRAMGW low exactly 1 cycle with addr 0x3F, done = 10 at cycle 3, Invalidate = 01, inval_addr = 0x3F.
- Both cores request together from reset → core 0 served first, then core 1. StallMe[1] stays high until its own done.
- Both cores request continuously for 6 transactions → grant sequence alternates 0,1,0,1,0,1; neither core is granted twice in a row.
- Reset asserted in the second READ cycle → SRAMOE high next edge, done and Invalidate stay 0, state returns to IDLE. A subsequent read completes normally.
- Core 0 drops req mid-write → write still performed, done[0] pulses, Invalidate[1] pulses. The next IDLE cycle shows no grant.
